spram_fifo_ctrl: RTL and testbench
==================================

Name: spram_fifo_ctrl

Overview:
Master-side controller for the single-port, async-read, sync-write RAM used in the RX datapath. It presents that RAM as a FIFO. Words arrive on an upstream valid/ready stream and are written into the RAM. They are later read back in order into a registered output stage that drives a downstream valid/ready stream. Each cycle the controller arbitrates the single RAM port between read and write. It sits between RX pipeline stages wherever a symbol-sized elastic buffer is needed.

Parameters:
DATA_WIDTH, 64, word width (matches RAM data width)
ADDR_WIDTH, 5, RAM address width
RAM_DEPTH, 32, RAM words; need not be a power of 2; must satisfy RAM_DEPTH <= 2^ADDR_WIDTH

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  reset, synchronous, active-high
iFlush  in  1  synchronous flush; empties the FIFO
iIn_Valid  in  1  upstream word valid
iData  in  DATA_WIDTH  upstream word
oIn_Ready  out  1  upstream ready (combinational)
oOut_Valid  out  1  downstream word valid (registered)
oData  out  DATA_WIDTH  downstream word (registered)
iOut_Ready  in  1  downstream ready
oRam_R_EN  out  1  RAM read enable
oRam_W_EN  out  1  RAM write enable
oRam_Addr  out  ADDR_WIDTH  RAM address
oRam_WData  out  DATA_WIDTH  RAM write data
iRam_RData  in  DATA_WIDTH  RAM async read data
oCount  out  ADDR_WIDTH+1  total words held (RAM plus output register), 0..RAM_DEPTH+1
oFull  out  1  RAM holds RAM_DEPTH words
oEmpty  out  1  oCount == 0

Behaviour:
- Clock and reset: one clock, iClk. Reset is iRst, synchronous and active-high.
- Reset state: wr_ptr, rd_ptr and mem_cnt are 0. oOut_Valid = 0, oData = 0, oCount = 0, oFull = 0, oEmpty = 1. RAM contents are not cleared by this block.
- Internal state: mem_cnt (ADDR_WIDTH+1 bits) counts words held in the RAM.
- Read request: rd_req = (mem_cnt != 0) && (!oOut_Valid || iOut_Ready).
- Read priority: a read request always wins the RAM port.
- Upstream ready: oIn_Ready = (mem_cnt < RAM_DEPTH) && !rd_req && !iFlush. This is a documented combinational path from iOut_Ready to oIn_Ready.
- Write grant: wr_go = iIn_Valid && oIn_Ready.
- Read cycle outputs: oRam_R_EN = 1, oRam_W_EN = 0, oRam_Addr = rd_ptr.
- Read cycle, at the clock edge: oData <= iRam_RData, oOut_Valid <= 1, rd_ptr advances, mem_cnt decrements.
- Write cycle outputs: oRam_W_EN = 1, oRam_R_EN = 0, oRam_Addr = wr_ptr.
- Write cycle, at the clock edge: wr_ptr advances, mem_cnt increments.
- Write data: oRam_WData = iData at all times.
- Idle cycle: both enables 0, oRam_Addr = 0.
- Mutual exclusion: oRam_R_EN and oRam_W_EN are never high in the same cycle.
- Output stage: if oOut_Valid && iOut_Ready and no read occurs that cycle, oOut_Valid <= 0 and oData holds. oData is stable while oOut_Valid && !iOut_Ready.
- Latency: a word accepted at edge t is in the RAM after t. Earliest read is cycle t+1, so oOut_Valid rises after edge t+1 (2 cycles input to output). There is no bypass path.
- Throughput: one RAM access per cycle. A sustained simultaneous stream runs at about 1 word per 2 cycles. Reads cannot be starved. Writes resume once reads drain the RAM or downstream stalls with the output register full.
- Pointer wrap: a pointer at RAM_DEPTH-1 wraps to 0. There is no power-of-2 assumption.
- Status: oCount = mem_cnt + oOut_Valid. oFull = (mem_cnt == RAM_DEPTH). oEmpty = (oCount == 0).
- Full boundary: with mem_cnt == RAM_DEPTH, oIn_Ready = 0. iIn_Valid is held by upstream and no word is lost or overwritten.
- Empty boundary: with mem_cnt == 0, no read is issued. oOut_Valid drops after the last word is consumed.
- Flush: iFlush = 1 at an edge gives the same pointer, count and output state as reset. No RAM access occurs in that cycle. iFlush and iRst behave identically for state; iRst has precedence.
- Reset or flush mid-transfer: a pending upstream word is not accepted that cycle. A presented output word is discarded.

Test Plan:
- Reset: assert iRst 2 cycles with iIn_Valid = 1 -> oIn_Ready = 0, no RAM enables, oOut_Valid = 0, oData = 0, oCount = 0, oEmpty = 1.
- Single word: write 64'hA5A5_0000_0000_0001 at cycle 0 with iOut_Ready = 1 -> W_EN at addr 0 in cycle 0; R_EN at addr 0 in cycle 1; oOut_Valid with matching oData after edge 1; oEmpty = 1 after it is consumed.
- Fill: iOut_Ready = 0, write 33 incrementing words -> first write fills the output register; after 33 words oFull = 1, oCount = 33, oIn_Ready = 0. Then set iOut_Ready = 1 -> 33 words out in order 0..32.
- Arbitration: iIn_Valid = 1 and iOut_Ready = 1 continuously from empty -> R_EN and W_EN never both high, output order equals input order, no cycle with a read when mem_cnt = 0.
- Wrap: RAM_DEPTH = 24, 100 random words with random valid/ready -> scoreboard match, oRam_Addr never >= 24, both pointers wrap past 23.
- Flush: 10 words stored, downstream stalled, pulse iFlush -> next cycle oCount = 0, oOut_Valid = 0; subsequent word 64'h1234 is written at addr 0 and read back correctly.

Source files
------------

// File: rtl/spram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// spram_fifo_ctrl
//
// Presents a single-port RAM (asynchronous read, synchronous write) as a FIFO.
// Upstream words are written into the RAM. They are read back in order into a
// registered output stage that drives a downstream valid/ready stream. The
// single RAM port is arbitrated every cycle, and a read request always wins.
//
// Ports:
//   iClk        clock, rising edge
//   iRst        synchronous active-high reset
//   iFlush      synchronous flush; empties the FIFO like reset
//   iIn_Valid   upstream word valid
//   iData       upstream word
//   oIn_Ready   upstream ready (combinational, depends on iOut_Ready)
//   oOut_Valid  downstream word valid (registered)
//   oData       downstream word (registered)
//   iOut_Ready  downstream ready
//   oRam_R_EN   RAM read enable
//   oRam_W_EN   RAM write enable
//   oRam_Addr   RAM address
//   oRam_WData  RAM write data (always iData)
//   iRam_RData  RAM asynchronous read data
//   oCount      words held in RAM plus output register, 0..RAM_DEPTH+1
//   oFull       RAM holds RAM_DEPTH words
//   oEmpty      oCount == 0
// -----------------------------------------------------------------------------
module spram_fifo_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int RAM_DEPTH  = 32
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iFlush,
    input  logic                  iIn_Valid,
    input  logic [DATA_WIDTH-1:0] iData,
    output logic                  oIn_Ready,
    output logic                  oOut_Valid,
    output logic [DATA_WIDTH-1:0] oData,
    input  logic                  iOut_Ready,
    output logic                  oRam_R_EN,
    output logic                  oRam_W_EN,
    output logic [ADDR_WIDTH-1:0] oRam_Addr,
    output logic [DATA_WIDTH-1:0] oRam_WData,
    input  logic [DATA_WIDTH-1:0] iRam_RData,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oFull,
    output logic                  oEmpty
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_cnt;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    logic                  clear;
    logic                  rd_req;
    logic                  rd_go;
    logic                  in_ready;
    logic                  wr_go;

    // Pointers wrap explicitly at the last RAM word, so RAM_DEPTH need not be
    // a power of two.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    endfunction

    // Reset and flush both suppress any RAM access and any upstream accept in
    // the cycle they are sampled.
    assign clear = iRst | iFlush;

    // A read is wanted whenever the RAM holds data and the output register
    // is free or is being emptied this cycle. Reads always win the port, which
    // makes oIn_Ready depend combinationally on iOut_Ready.
    assign rd_req   = (mem_cnt != '0) && (!out_valid || iOut_Ready);
    assign rd_go    = rd_req && !clear;
    assign in_ready = (mem_cnt < DEPTH_CNT) && !rd_req && !clear;
    assign wr_go    = iIn_Valid && in_ready;

    assign oIn_Ready  = in_ready;
    assign oRam_WData = iData;

    // RAM port mux: read, write or idle (address parked at 0 when idle).
    always_comb begin
        oRam_R_EN = 1'b0;
        oRam_W_EN = 1'b0;
        oRam_Addr = '0;
        if (rd_go) begin
            oRam_R_EN = 1'b1;
            oRam_Addr = rd_ptr;
        end else if (wr_go) begin
            oRam_W_EN = 1'b1;
            oRam_Addr = wr_ptr;
        end
    end

    // Pointer, count and output-register state. rd_go and wr_go are mutually
    // exclusive, so mem_cnt moves by at most one per cycle. A read refills the
    // output register even when it is being consumed in the same cycle.
    always_ff @(posedge iClk) begin
        if (iRst || iFlush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (rd_go) begin
                rd_ptr    <= next_ptr(rd_ptr);
                mem_cnt   <= mem_cnt - 1'b1;
                out_data  <= iRam_RData;
                out_valid <= 1'b1;
            end else begin
                if (wr_go) begin
                    wr_ptr  <= next_ptr(wr_ptr);
                    mem_cnt <= mem_cnt + 1'b1;
                end
                if (out_valid && iOut_Ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign oOut_Valid = out_valid;
    assign oData      = out_data;

    // The output register counts as one more held word.
    assign oCount = mem_cnt + {{ADDR_WIDTH{1'b0}}, out_valid};
    assign oFull  = (mem_cnt == DEPTH_CNT);
    assign oEmpty = (oCount == '0);

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spram_fifo_ctrl
//
// Testbench for spram_fifo_ctrl. Two instances share the stimulus: dut_a uses
// the default 32-word RAM, and dut_b uses a 24-word RAM to exercise
// non-power-of-two pointer wrap. Each instance has its own behavioural RAM
// with asynchronous read and synchronous write.
// -----------------------------------------------------------------------------
module tb_spram_fifo_ctrl;

    logic        iClk;
    logic        iRst;
    logic        iFlush;
    logic        iIn_Valid;
    logic [63:0] iData;
    logic        iOut_Ready;

    logic        a_in_ready, a_out_valid, a_r_en, a_w_en, a_full, a_empty;
    logic [63:0] a_out_data, a_wdata, a_rdata;
    logic [4:0]  a_addr;
    logic [5:0]  a_count;

    logic        b_in_ready, b_out_valid, b_r_en, b_w_en, b_full, b_empty;
    logic [63:0] b_out_data, b_wdata, b_rdata;
    logic [4:0]  b_addr;
    logic [5:0]  b_count;

    logic [63:0] ram_a [0:31];
    logic [63:0] ram_b [0:31];

    int checks = 0;
    int errors = 0;

    spram_fifo_ctrl dut_a (
        .iClk(iClk), .iRst(iRst), .iFlush(iFlush),
        .iIn_Valid(iIn_Valid), .iData(iData), .oIn_Ready(a_in_ready),
        .oOut_Valid(a_out_valid), .oData(a_out_data), .iOut_Ready(iOut_Ready),
        .oRam_R_EN(a_r_en), .oRam_W_EN(a_w_en), .oRam_Addr(a_addr),
        .oRam_WData(a_wdata), .iRam_RData(a_rdata),
        .oCount(a_count), .oFull(a_full), .oEmpty(a_empty)
    );

    spram_fifo_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .RAM_DEPTH(24)) dut_b (
        .iClk(iClk), .iRst(iRst), .iFlush(iFlush),
        .iIn_Valid(iIn_Valid), .iData(iData), .oIn_Ready(b_in_ready),
        .oOut_Valid(b_out_valid), .oData(b_out_data), .iOut_Ready(iOut_Ready),
        .oRam_R_EN(b_r_en), .oRam_W_EN(b_w_en), .oRam_Addr(b_addr),
        .oRam_WData(b_wdata), .iRam_RData(b_rdata),
        .oCount(b_count), .oFull(b_full), .oEmpty(b_empty)
    );

    // Behavioural RAMs: synchronous write, asynchronous read.
    always @(posedge iClk) begin
        if (a_w_en) ram_a[a_addr] <= a_wdata;
        if (b_w_en) ram_b[b_addr] <= b_wdata;
    end
    assign a_rdata = ram_a[a_addr];
    assign b_rdata = ram_b[b_addr];

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iFlush = 1'b0; iIn_Valid = 1'b1; iData = 64'hDEAD_BEEF; iOut_Ready = 1'b1;
        step();
        step();
        @(negedge iClk);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 0", a_in_ready); end
        checks++; if (a_r_en !== 1'b0 || a_w_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_en: got r=%0b w=%0b want 0 0", a_r_en, a_w_en); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b want 0", a_out_valid); end
        checks++; if (a_out_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", a_out_data); end
        checks++; if (a_count !== 6'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", a_count); end
        checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got empty=%0b full=%0b want 1 0", a_empty, a_full); end
        step();
        iRst = 1'b0; iIn_Valid = 1'b0;
    endtask

    task automatic test_single();
        iOut_Ready = 1'b1; iIn_Valid = 1'b1; iData = 64'hA5A5_0000_0000_0001;
        @(negedge iClk);
        checks++; if (a_w_en !== 1'b1 || a_r_en !== 1'b0 || a_addr !== 5'd0) begin errors++; $display("[TB] FAIL single_write: got w=%0b r=%0b addr=%0d want 1 0 0", a_w_en, a_r_en, a_addr); end
        checks++; if (a_wdata !== 64'hA5A5_0000_0000_0001) begin errors++; $display("[TB] FAIL single_wdata: got %h want a5a5000000000001", a_wdata); end
        step();
        iIn_Valid = 1'b0;
        @(negedge iClk);
        checks++; if (a_r_en !== 1'b1 || a_w_en !== 1'b0 || a_addr !== 5'd0) begin errors++; $display("[TB] FAIL single_read: got r=%0b w=%0b addr=%0d want 1 0 0", a_r_en, a_w_en, a_addr); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_latency: got out_valid=%0b want 0", a_out_valid); end
        step();
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 64'hA5A5_0000_0000_0001) begin errors++; $display("[TB] FAIL single_out: got v=%0b d=%h want 1 a5a5000000000001", a_out_valid, a_out_data); end
        checks++; if (a_count !== 6'd1) begin errors++; $display("[TB] FAIL single_count: got %0d want 1", a_count); end
        step();
        checks++; if (a_out_valid !== 1'b0 || a_empty !== 1'b1) begin errors++; $display("[TB] FAIL single_drain: got v=%0b empty=%0b want 0 1", a_out_valid, a_empty); end
    endtask

    task automatic test_fill();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        iOut_Ready = 1'b0; iIn_Valid = 1'b1; iData = 64'h100;
        while (sent < 33 && cyc < 300) begin
            @(negedge iClk);
            checks++; if (a_r_en && a_w_en) begin errors++; $display("[TB] FAIL fill_mutex: got r=1 w=1 want exclusive"); end
            if (a_in_ready) sent++;
            step();
            cyc++;
            if (sent < 33) iData = 64'h100 + 64'(sent);
            else iIn_Valid = 1'b0;
        end
        checks++; if (sent != 33) begin errors++; $display("[TB] FAIL fill_accept: got %0d words want 33", sent); end
        iIn_Valid = 1'b0;
        @(negedge iClk);
        checks++; if (a_full !== 1'b1 || a_count !== 6'd33) begin errors++; $display("[TB] FAIL fill_status: got full=%0b count=%0d want 1 33", a_full, a_count); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_in_ready: got %0b want 0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h100) begin errors++; $display("[TB] FAIL fill_head: got v=%0b d=%h want 1 100", a_out_valid, a_out_data); end
        step();
        iOut_Ready = 1'b1;
        cyc = 0;
        while (got < 33 && cyc < 300) begin
            @(negedge iClk);
            if (a_out_valid) begin
                checks++; if (a_out_data !== 64'h100 + 64'(got)) begin errors++; $display("[TB] FAIL fill_order: got %h want %h", a_out_data, 64'h100 + 64'(got)); end
                got++;
            end
            step();
            cyc++;
        end
        @(negedge iClk);
        checks++; if (got != 33 || a_empty !== 1'b1) begin errors++; $display("[TB] FAIL fill_drain: got %0d words empty=%0b want 33 1", got, a_empty); end
        step();
    endtask

    task automatic test_arbitration();
        logic [63:0] exp_q[$];
        int  ram_cnt = 0;
        int  n_in = 0;
        int  n_out = 0;
        bit  accepted;
        iOut_Ready = 1'b1; iIn_Valid = 1'b1; iData = 64'hB000;
        for (int c = 0; c < 140; c++) begin
            @(negedge iClk);
            checks++; if (a_r_en && a_w_en) begin errors++; $display("[TB] FAIL arb_mutex: got r=1 w=1 want exclusive"); end
            if (a_r_en) begin
                checks++; if (ram_cnt == 0) begin errors++; $display("[TB] FAIL arb_empty_read: got read with ram count 0 want no read"); end
                else ram_cnt--;
            end
            if (a_w_en) ram_cnt++;
            accepted = iIn_Valid && a_in_ready;
            if (accepted) begin
                exp_q.push_back(iData);
                n_in++;
            end
            if (a_out_valid && iOut_Ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL arb_order: got %h want nothing", a_out_data); end
                else begin
                    if (a_out_data !== exp_q[0]) begin errors++; $display("[TB] FAIL arb_order: got %h want %h", a_out_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                n_out++;
            end
            step();
            if (c >= 80) iIn_Valid = 1'b0;
            else if (accepted) iData = iData + 64'd1;
        end
        checks++; if (n_in < 30 || n_out != n_in || exp_q.size() != 0) begin errors++; $display("[TB] FAIL arb_totals: got in=%0d out=%0d left=%0d want in>=30 out=in left=0", n_in, n_out, exp_q.size()); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_q[$];
        int  wr_exp = 0;
        int  rd_exp = 0;
        int  n_in = 0;
        int  n_out = 0;
        bit  wr_wrap = 1'b0;
        bit  rd_wrap = 1'b0;
        bit  accepted;
        iRst = 1'b1; iIn_Valid = 1'b0;
        step();
        iRst = 1'b0;
        for (int c = 0; c < 3000 && n_out < 100; c++) begin
            iOut_Ready = 1'($urandom_range(0, 1));
            if (!iIn_Valid && n_in < 100 && $urandom_range(0, 2) != 0) begin
                iIn_Valid = 1'b1;
                iData = {$urandom, $urandom};
            end
            @(negedge iClk);
            checks++; if (b_addr >= 5'd24) begin errors++; $display("[TB] FAIL wrap_addr_range: got %0d want <24", b_addr); end
            if (b_w_en) begin
                checks++; if (b_addr !== 5'(wr_exp)) begin errors++; $display("[TB] FAIL wrap_wr_addr: got %0d want %0d", b_addr, wr_exp); end
                if (wr_exp == 23) wr_wrap = 1'b1;
                wr_exp = (wr_exp + 1) % 24;
            end
            if (b_r_en) begin
                checks++; if (b_addr !== 5'(rd_exp)) begin errors++; $display("[TB] FAIL wrap_rd_addr: got %0d want %0d", b_addr, rd_exp); end
                if (rd_exp == 23) rd_wrap = 1'b1;
                rd_exp = (rd_exp + 1) % 24;
            end
            accepted = iIn_Valid && b_in_ready;
            if (accepted) begin
                exp_q.push_back(iData);
                n_in++;
            end
            if (b_out_valid && iOut_Ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL wrap_order: got %h want nothing", b_out_data); end
                else begin
                    if (b_out_data !== exp_q[0]) begin errors++; $display("[TB] FAIL wrap_order: got %h want %h", b_out_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                n_out++;
            end
            step();
            if (accepted) iIn_Valid = 1'b0;
        end
        iIn_Valid = 1'b0;
        checks++; if (n_out != 100 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL wrap_totals: got out=%0d left=%0d want 100 0", n_out, exp_q.size()); end
        checks++; if (!wr_wrap || !rd_wrap) begin errors++; $display("[TB] FAIL wrap_pointers: got wr_wrap=%0b rd_wrap=%0b want 1 1", wr_wrap, rd_wrap); end
    endtask

    task automatic test_flush();
        int sent = 0;
        int cyc  = 0;
        bit seen = 1'b0;
        iOut_Ready = 1'b0; iIn_Valid = 1'b1; iData = 64'hC00;
        while (sent < 10 && cyc < 100) begin
            @(negedge iClk);
            if (a_in_ready) sent++;
            step();
            cyc++;
            if (sent < 10) iData = 64'hC00 + 64'(sent);
            else iIn_Valid = 1'b0;
        end
        checks++; if (sent != 10) begin errors++; $display("[TB] FAIL flush_fill: got %0d words want 10", sent); end
        iIn_Valid = 1'b1; iData = 64'hEEEE; iFlush = 1'b1;
        @(negedge iClk);
        checks++; if (a_count !== 6'd10) begin errors++; $display("[TB] FAIL flush_precount: got %0d want 10", a_count); end
        checks++; if (a_in_ready !== 1'b0 || a_r_en !== 1'b0 || a_w_en !== 1'b0) begin errors++; $display("[TB] FAIL flush_cycle: got ready=%0b r=%0b w=%0b want 0 0 0", a_in_ready, a_r_en, a_w_en); end
        step();
        iFlush = 1'b0;
        checks++; if (a_count !== 6'd0 || a_out_valid !== 1'b0 || a_empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_state: got count=%0d v=%0b empty=%0b want 0 0 1", a_count, a_out_valid, a_empty); end
        iIn_Valid = 1'b1; iData = 64'h1234; iOut_Ready = 1'b1;
        @(negedge iClk);
        checks++; if (a_w_en !== 1'b1 || a_addr !== 5'd0) begin errors++; $display("[TB] FAIL flush_write_addr: got w=%0b addr=%0d want 1 0", a_w_en, a_addr); end
        step();
        iIn_Valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge iClk);
            if (a_out_valid) begin
                seen = 1'b1;
                checks++; if (a_out_data !== 64'h1234) begin errors++; $display("[TB] FAIL flush_readback: got %h want 1234", a_out_data); end
            end
            step();
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL flush_readback_timeout: got no output want 1234"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_arbitration();
        test_wrap();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
